// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a registered carry,
// operands consumed LSB-first, one bit per clock, parallel result on a done pulse.
`timescale 1ns/1ps

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               faSum;
    logic               faCarry;

    full_adder u_fa (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .c_i (carry_q),
        .s_o (faSum),
        .c_o (faCarry)
    );

    // Each new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign acc_d = {faSum, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    carry_q <= faCarry;
                    acc_q   <= acc_d;
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Results are published only on the final bit, never as partial sums.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q   <= acc_d;
                        cout_q  <= faCarry;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table-driven 8-bit vectors, multi-cycle
// corner sequences, and an exhaustive back-to-back run on a 4-bit instance.
`timescale 1ns/1ps

module tb_serial_adder;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expSum;
        logic       expCout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp8Q[$];
    logic [4:0] exp4Q[$];
    logic [7:0] lastSum8 = '0;
    logic       lastCout8 = 1'b0;
    logic       done8Prev = 1'b0;
    logic       done4Prev = 1'b0;
    int         nDone4 = 0;
    longint     lastDone4 = 0;
    vec_t       vecs[7];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the 8-bit instance: every done pops one expected result.
    always @(negedge clk) begin
        logic [8:0] e;
        if (done8) begin
            if (exp8Q.size() == 0) begin
                checkOutput("dut8 unexpected done", 32'd1, 32'd0);
            end else begin
                e = exp8Q.pop_front();
                checkOutput("dut8 {cout,sum}", {23'd0, cout8, sum8}, {23'd0, e});
            end
        end
        if (done8Prev) checkOutput("dut8 done width", {31'd0, done8}, 32'd0);
        done8Prev = done8;
    end

    // Scoreboard for the 4-bit instance, plus period and pulse-width checks.
    always @(negedge clk) begin
        logic [4:0] e;
        if (done4) begin
            if (exp4Q.size() == 0) begin
                checkOutput("dut4 unexpected done", 32'd1, 32'd0);
            end else begin
                e = exp4Q.pop_front();
                checkOutput("dut4 {cout,sum}", {27'd0, cout4, sum4}, {27'd0, e});
            end
            if (nDone4 > 0) checkOutput("dut4 period cycles", 32'(($time - lastDone4) / 10), 32'd6);
            lastDone4 = $time;
            nDone4++;
        end
        if (done4Prev) checkOutput("dut4 done width", {31'd0, done4}, 32'd0);
        done4Prev = done4;
    end

    task automatic applyStimulus(input vec_t v);
        int  busyCnt;
        bit  got;
        @(negedge clk);
        a8     = v.a;
        b8     = v.b;
        cin8   = v.cin;
        start8 = 1'b1;
        exp8Q.push_back({v.expCout, v.expSum});
        busyCnt = 0;
        got     = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8) begin
                busyCnt++;
                checkOutput({v.name, " sum hold"}, {24'd0, sum8}, {24'd0, lastSum8});
                checkOutput({v.name, " cout hold"}, {31'd0, cout8}, {31'd0, lastCout8});
            end
            if (done8) begin
                got = 1;
                checkOutput({v.name, " done latency"}, 32'(c), 32'd9);
            end
        end
        if (!got) checkOutput({v.name, " done timeout"}, 32'd0, 32'd1);
        checkOutput({v.name, " busy cycles"}, 32'(busyCnt), 32'd8);
        lastSum8  = v.expSum;
        lastCout8 = v.expCout;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCnt;

        vecs[0] = '{"basic",      8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{"carryChain", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{"allOnes",    8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{"zeros",      8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{"msbCarry",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{"cinRipple",  8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{"mixed",      8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

        // Outputs must clear from reset alone, before any clock edge.
        #3;
        checkOutput("reset busy", {31'd0, busy8}, 32'd0);
        checkOutput("reset done", {31'd0, done8}, 32'd0);
        checkOutput("reset sum", {24'd0, sum8}, 32'd0);
        checkOutput("reset cout", {31'd0, cout8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Start pulses and operand changes during ADD must not disturb the op.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        exp8Q.push_back({1'b0, 8'h10});
        doneCnt = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start8 = (c == 2);
            if (c == 2) begin
                a8 = 8'hAA; b8 = 8'h55;
            end else if (c <= 8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            if (busy8) checkOutput("ignored sum hold", {24'd0, sum8}, {24'd0, lastSum8});
            if (done8) doneCnt++;
        end
        checkOutput("ignored done count", 32'(doneCnt), 32'd1);
        lastSum8 = 8'h10; lastCout8 = 1'b0;

        // Abort in the 4th ADD cycle: async clear, no done afterwards.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        exp8Q.push_back({1'b0, 8'h44});
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        exp8Q.delete();
        #1;
        checkOutput("midop busy", {31'd0, busy8}, 32'd0);
        checkOutput("midop done", {31'd0, done8}, 32'd0);
        checkOutput("midop sum", {24'd0, sum8}, 32'd0);
        checkOutput("midop cout", {31'd0, cout8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput("post-reset no done", {31'd0, done8}, 32'd0);
        end
        lastSum8 = 8'h00; lastCout8 = 1'b0;
        applyStimulus('{"afterReset", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0});

        // Exhaustive back-to-back on WIDTH=4 with start held high: new operands every 6 cycles.
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
            exp4Q.push_back(5'(a4) + 5'(b4) + 5'(cin4));
            repeat (6) @(negedge clk);
        end
        start4 = 1'b0;
        for (int c = 0; c < 20 && exp4Q.size() != 0; c++) @(negedge clk);
        checkOutput("dut4 pending results", 32'(exp4Q.size()), 32'd0);
        checkOutput("dut4 done count", 32'(nDone4), 32'd512);
        checkOutput("dut8 pending results", 32'(exp8Q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
